// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-requester round-robin port arbiter.
//
// Contents:
//   arb_state_t - arbitration FSM state (idle, or owned by requester 0 / 1)
//   cnt_width() - width of the per-grant beat counter for a given beat limit
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // The counter only has to reach max_beats-1, so $clog2(max_beats) bits
    // are enough and it can never wrap.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats);
    endfunction

endpackage : arb_pkg

// File: rtl/mux2_1_VAR.sv
// Generic WIDTH-bit 2:1 multiplexer.
//
// Ports:
//   sel - select; 0 passes a, 1 passes b
//   a   - input 0
//   b   - input 1
//   y   - selected output
module mux2_1_VAR #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule : mux2_1_VAR

// File: rtl/arb2_rr_port.sv
// Two-requester round-robin arbiter for one shared WIDTH-bit port.
// Ownership is granted one cycle after a request is seen in IDLE and held
// across a burst until the owner's last beat is accepted or MAX_BEATS beats
// have been accepted; every grant is followed by at least one IDLE cycle.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req/last/data 0,1   - requester beat valid, end-of-burst, payload
//   gnt0, gnt1          - requester currently owns the port
//   ack0, ack1          - requester beat accepted this cycle
//   out_valid/last/data - shared port beat towards the consumer
//   out_ready           - consumer accepts the beat
//   owner               - index of the current owner (valid when granted)
module arb2_rr_port
    import arb_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MAX_BEATS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             last0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             last1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             owner
);

    localparam int CW = cnt_width(MAX_BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

    arb_state_t    state, state_n;
    logic          prio, prio_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic          sel_last;
    logic          busy;
    logic          accept;

    // Data path: both the payload and the last flag follow the owner.
    mux2_1_VAR #(.WIDTH(WIDTH)) u_data_mux (
        .sel (owner),
        .a   (data0),
        .b   (data1),
        .y   (out_data)
    );

    mux2_1_VAR #(.WIDTH(1)) u_last_mux (
        .sel (owner),
        .a   (last0),
        .b   (last1),
        .y   (sel_last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    assign busy      = (state == OWN0) || (state == OWN1);
    assign out_last  = busy & sel_last;
    assign out_valid = (state == OWN0) ? req0 :
                       (state == OWN1) ? req1 : 1'b0;
    assign accept    = out_valid & out_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_n    = state;
        prio_n     = prio;
        beat_cnt_n = beat_cnt;
        owner      = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_n = prio ? OWN1 : OWN0;
                end else if (req0) begin
                    state_n = OWN0;
                end else if (req1) begin
                    state_n = OWN1;
                end
            end

            OWN0, OWN1: begin
                owner = (state == OWN1);
                gnt0  = (state == OWN0);
                gnt1  = (state == OWN1);
                ack0  = gnt0 & accept;
                ack1  = gnt1 & accept;
                // A bubble (owner req low) leaves both state and count alone.
                if (accept) begin
                    if (sel_last || beat_cnt == LAST_CNT) begin
                        state_n    = IDLE;
                        prio_n     = ~owner;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + CW'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule : arb2_rr_port

// File: tb/tb_arb2_rr_port.sv
// Directed testbench for arb2_rr_port (WIDTH=64, MAX_BEATS=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 2 time units after the edge, well clear of either clock edge.
module tb_arb2_rr_port;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, last0, req1, last1, out_ready;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, ack0, ack1, out_valid, out_last, owner;
    logic [WIDTH-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arb2_rr_port #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .last0     (last0),
        .data0     (data0),
        .req1      (req1),
        .last1     (last1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the edge for new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Compact status check: {gnt0, gnt1, ack0, ack1, out_valid}
    task automatic status(input string tag, input logic [4:0] exp);
        check(tag, {gnt0, gnt1, ack0, ack1, out_valid}, exp);
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
        data0 = 64'hA; data1 = 64'hB; out_ready = 1'b1;

        // 1. Reset with both requesting
        tick(); tick(); settle();
        status("rst_idle", 5'b00000);
        check("rst_owner", owner, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 64'hA);
        reset = 1'b0;

        // 2. Single-beat alternation, prio=0 first
        tick(); settle();
        status("alt_own0", 5'b10101);
        check("alt_data0", out_data, 64'hA);
        check("alt_last0", out_last, 1);
        tick(); settle();
        status("alt_idle1", 5'b00000);
        tick(); settle();
        status("alt_own1", 5'b01011);
        check("alt_data1", out_data, 64'hB);
        check("alt_owner1", owner, 1);
        tick(); settle();
        status("alt_idle2", 5'b00000);
        tick(); settle();
        status("alt_own0b", 5'b10101);
        tick();                       // beat accepted, now IDLE with prio=1
        req0 = 1'b0; req1 = 1'b0; settle();
        status("alt_quiet", 5'b00000);

        // 3. Requester 1 burst of 3 beats, ready toggling 1,0,1,0,1
        req1 = 1'b1; last1 = 1'b0; data1 = 64'h11;
        tick();
        out_ready = 1'b1; settle();
        status("bp_c1", 5'b01011);
        check("bp_d1", out_data, 64'h11);
        tick(); data1 = 64'h12; out_ready = 1'b0; settle();
        status("bp_c2", 5'b01001);
        tick(); out_ready = 1'b1; settle();
        status("bp_c3", 5'b01011);
        check("bp_d2", out_data, 64'h12);
        tick(); data1 = 64'h13; last1 = 1'b1; out_ready = 1'b0; settle();
        status("bp_c4", 5'b01001);
        tick(); out_ready = 1'b1; settle();
        status("bp_c5", 5'b01011);
        check("bp_last", out_last, 1);
        check("bp_d3", out_data, 64'h13);
        tick(); req1 = 1'b0; settle();
        status("bp_release", 5'b00000);

        // 4. Forced release: req0 streams without last, req1 waiting (prio=0)
        req0 = 1'b1; last0 = 1'b0; req1 = 1'b1; last1 = 1'b1;
        tick(); settle();
        for (int i = 0; i < 4; i++) begin
            data0 = 64'h100 + 64'(i); settle();
            status($sformatf("fr_beat%0d", i), 5'b10101);
            check($sformatf("fr_data%0d", i), out_data, 64'h100 + 64'(i));
            check($sformatf("fr_last%0d", i), out_last, 0);
            tick();
        end
        settle();
        status("fr_idle", 5'b00000);
        tick(); settle();
        status("fr_own1", 5'b01011);
        tick(); req1 = 1'b0; settle();
        status("fr_idle2", 5'b00000);
        tick(); settle();
        status("fr_regrant0", 5'b10101);

        // 5. Owner bubble: fresh OWN0 grant, req0 low for 2 cycles
        req0 = 1'b0; req1 = 1'b1; settle();
        status("bub_c1", 5'b10000);
        tick(); settle();
        status("bub_c2", 5'b10000);
        tick(); req0 = 1'b1; last0 = 1'b0; settle();
        // Count must still be 0: four more accepts before forced release.
        for (int i = 0; i < 4; i++) begin
            status($sformatf("bub_beat%0d", i), 5'b10101);
            tick(); settle();
        end
        status("bub_release", 5'b00000);

        // 6. Reset mid-burst on requester 1 (prio is 1 here; reset clears it)
        req0 = 1'b0; req1 = 1'b1; last1 = 1'b0;
        tick(); settle();
        status("mr_beat1", 5'b01011);
        tick(); reset = 1'b1; settle();
        tick(); settle();
        status("mr_idle", 5'b00000);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        tick(); settle();
        status("mr_prio0", 5'b10101);
        check("mr_owner", owner, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_arb2_rr_port

// File: doc/arb2_rr_port.md
Name: arb2_rr_port

Overview:
- Two-requester round-robin arbiter that shares one WIDTH-bit datapath port, e.g. a memory or register write port, between two masters.
- It owns the 2:1 data select, arbitrates between requesters and holds ownership across multi-beat bursts.
- A beat limit forces release so that neither requester can starve the other.
- It sits between two producer stages and a single consumer with a valid/ready input.

Parameters:
- WIDTH, 64, bit width of each requester's data and of the shared output data.
- MAX_BEATS, 4, maximum number of accepted beats per grant before forced release; legal range 2..256.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  requester 0 presents a valid beat
- last0  input  1  requester 0 beat is the final beat of its burst
- data0  input  WIDTH  requester 0 beat data
- req1  input  1  requester 1 presents a valid beat
- last1  input  1  requester 1 beat is the final beat of its burst
- data1  input  WIDTH  requester 1 beat data
- gnt0  output  1  requester 0 currently owns the port
- gnt1  output  1  requester 1 currently owns the port
- ack0  output  1  requester 0 beat accepted this cycle
- ack1  output  1  requester 1 beat accepted this cycle
- out_valid  output  1  shared port beat valid
- out_last  output  1  shared port beat is last
- out_data  output  WIDTH  shared port data
- out_ready  input  1  consumer accepts the beat
- owner  output  1  index of current owner; meaningful only when gnt0|gnt1

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- FSM states: IDLE, OWN0, OWN1. State, priority pointer prio (1 bit) and beat_cnt are registered.
- Reset values (also on reset asserted mid-burst, effective next edge):
  - state = IDLE, prio = 0, beat_cnt = 0.
  - Outputs therefore: gnt0 = gnt1 = 0, ack0 = ack1 = 0, out_valid = 0, out_last = 0, owner = 0, out_data = data0 (select = 0).
  - Any in-flight burst is abandoned; no completion is signalled.
- IDLE transitions:
  - No req: stay in IDLE.
  - Exactly one req: go to that requester's OWN state.
  - Both req: go to OWN[prio].
  - Grant is registered, so arbitration latency is 1 cycle from a req seen in IDLE to gnt high.
- OWNx outputs:
  - gntx = 1, owner = x, select = x.
  - out_valid = reqx, out_last = lastx, out_data = datax.
  - All three are combinational from the current state and the owner's inputs.
- Transfer: beat accepted when out_valid & out_ready. ackx = that condition, combinational; the other ack stays 0.
- Owner deasserts req while owning: out_valid = 0, ownership retained (bubble), beat_cnt unchanged.
- On each accepted beat:
  - If lastx = 1, or beat_cnt == MAX_BEATS-1: release. Next state = IDLE, prio <= ~x, beat_cnt <= 0.
  - Otherwise: beat_cnt <= beat_cnt + 1.
- Every grant therefore has at least one IDLE cycle after it. Back-to-back grants cost 1 bubble cycle.
- Forced release does not alter out_last. The requester keeps presenting its burst and is re-arbitrated against the other requester.
- Non-owner inputs are ignored entirely; the non-owner's ack stays 0.
- Both requesters asserting together while one owns the port: no effect until release.
- beat_cnt width is $clog2(MAX_BEATS). It never wraps, because release occurs at MAX_BEATS-1.
- out_ready high in IDLE has no effect.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - localparam helper for the beat counter width
- Data path: instantiate the team's existing WIDTH-parameterised 2:1 mux (mux2_1_VAR) as the single sub-module. Select = owner; also apply it to last0/last1 via a WIDTH=1 instance.
- Arbitration and FSM logic stay in arb2_rr_port.

Test Plan:
1. Reset and idle:
   - Stimulus: reset=1 for 2 cycles with req0=req1=1.
   - Required: gnt0=gnt1=0, out_valid=0. After reset drops, next cycle gnt0=1 (prio=0).
2. Single-beat alternation:
   - Stimulus: req0=req1=1, last0=last1=1, out_ready=1, data0=64'hA, data1=64'hB.
   - Required grant sequence: OWN0 (out_data=A, ack0), IDLE, OWN1 (out_data=B, ack1), IDLE, OWN0. Strict alternation.
3. Burst hold with backpressure:
   - Stimulus: requester 1 only, 3 beats with last on beat 3; out_ready toggles 1,0,1,0,1.
   - Required: gnt1 held for all 5 cycles; ack1 only on ready cycles; release after the third accept.
4. Forced release:
   - Stimulus: MAX_BEATS=4; req0 streams 6 beats with last0=0, req1=1, out_ready=1.
   - Required: after 4 accepted beats, release to IDLE, then gnt1; requester 0 is regranted after requester 1 finishes.
5. Owner bubble:
   - Stimulus: while OWN0, req0 drops for 2 cycles, req1=1.
   - Required: out_valid=0, gnt0 stays 1, gnt1 stays 0, beat_cnt unchanged.
6. Reset mid-burst:
   - Stimulus: assert reset during beat 2 of a requester-1 burst.
   - Required: next edge state=IDLE, gnt1=0, prio=0, and no ack in that cycle after reset.
